// File: rtl/clk_meter_pkg.sv
// rtl/clk_meter_pkg.sv - shared state encoding and default constants for clk_period_meter
// Contents:
//   meter_state_t   IDLE / ARM / MEAS measurement states
//   *_DEF           default parameter values used by clk_period_meter
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } meter_state_t;

  localparam int CNT_W_DEF       = 16;
  localparam int TIMEOUT_DEF     = 65000;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILTER_LEN_DEF  = 3;

endpackage

// File: rtl/clk_meter_sync.sv
// rtl/clk_meter_sync.sv - synchronizer, optional glitch filter and rising-edge detect for clk_in
// Optional feature macro: CLK_METER_FILTER_EN (adds the FILTER_LEN stability filter)
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   clk_in  in   slow clock, asynchronous to clk
//   f_lvl   out  synchronized (and filtered) level of clk_in
//   rise    out  combinational: f_lvl high while its previous-cycle value was low
module clk_meter_sync #(
  parameter int SYNC_STAGES = 2
`ifdef CLK_METER_FILTER_EN
  ,
  parameter int FILTER_LEN  = 3
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_in,
  output logic f_lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_lvl;
  logic                   f_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
    end
  end

  assign s_lvl = sync_q[SYNC_STAGES-1];

`ifdef CLK_METER_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic [FW-1:0] fcnt;
  logic          f_q;

  // fcnt counts consecutive cycles in which s_lvl disagrees with the filtered
  // level; the level only follows once the disagreement has lasted FILTER_LEN
  // cycles, and any agreeing cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
      f_q  <= 1'b0;
    end else if (s_lvl != f_q) begin
      if (fcnt == FW'(FILTER_LEN - 1)) begin
        f_q  <= s_lvl;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end else begin
      fcnt <= '0;
    end
  end

  assign f_lvl = f_q;
`else
  assign f_lvl = s_lvl;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_prev <= 1'b0;
    end else begin
      f_prev <= f_lvl;
    end
  end

  assign rise = f_lvl & ~f_prev;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures period and high time of a slow clock in clk cycles
// Optional feature macro: CLK_METER_FILTER_EN (glitch filter on the synchronized input)
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   enable        in   measurement enable
//   clk_in        in   slow clock under measurement, asynchronous to clk
//   edge_tick     out  one-cycle pulse per detected clk_in rising edge
//   period        out  clk cycles between the last two rising edges
//   high_time     out  clk cycles clk_in was high within that period
//   period_valid  out  result available, held until accepted
//   period_ready  in   consumer accepts result
//   overrun       out  sticky: an unaccepted result was overwritten
//   timeout       out  sticky: no edge within TIMEOUT cycles
//   clr           in   clears overrun and timeout
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int FILTER_LEN  = FILTER_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clk_in,
  output logic             edge_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overrun,
  output logic             timeout,
  input  logic             clr
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1 || TIMEOUT < 1 ||
      TIMEOUT > (2 ** CNT_W) - 1) begin : g_param_check
    $error("clk_period_meter: illegal parameter combination");
  end

  // cnt is zero in the first cycle after an edge, so it holds TIMEOUT-1 in the
  // cycle that completes TIMEOUT edge-free cycles.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  meter_state_t     state;
  meter_state_t     state_nxt;
  logic             f_lvl;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic             measuring;
  logic             load;
  logic             to_hit;
  logic             xfer;

  clk_meter_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef CLK_METER_FILTER_EN
    ,
    .FILTER_LEN (FILTER_LEN)
`endif
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .clk_in(clk_in),
    .f_lvl (f_lvl),
    .rise  (rise)
  );

  assign measuring = enable && (state == MEAS);
  assign load      = measuring && rise;
  assign to_hit    = measuring && !rise && (cnt == TO_LAST);
  assign xfer      = period_valid && period_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (rise) state_nxt = MEAS;
        MEAS:    if (to_hit) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counters run only while measuring and restart on every edge or timeout,
  // so cnt never exceeds TIMEOUT-1 and cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (!measuring || rise || to_hit) begin
      cnt  <= '0;
      hcnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (f_lvl) begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // The edge cycle itself is the first high cycle of the new period and the
  // last cycle of the old one; neither counter has seen it, hence both +1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_tick    <= 1'b0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
    end else begin
      edge_tick <= rise;
      if (load) begin
        period       <= cnt + 1'b1;
        high_time    <= hcnt + 1'b1;
        period_valid <= 1'b1;
      end else if (xfer) begin
        period_valid <= 1'b0;
      end
    end
  end

  // Set events take priority over clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (load && period_valid && !period_ready) begin
        overrun <= 1'b1;
      end else if (clr) begin
        overrun <= 1'b0;
      end
      if (to_hit) begin
        timeout <= 1'b1;
      end else if (clr) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - self-checking bench for clk_period_meter (TIMEOUT=100)
// Optional feature macro: CLK_METER_FILTER_EN (changes the glitch expectations)
module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int TO    = 100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             clk_in = 1'b0;
  logic             period_ready = 1'b0;
  logic             clr = 1'b0;
  logic             edge_tick;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             overrun;
  logic             timeout;

  always #5 clk = ~clk;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .TIMEOUT    (TO),
    .FILTER_LEN (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clk_in      (clk_in),
    .edge_tick   (edge_tick),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .overrun     (overrun),
    .timeout     (timeout),
    .clr         (clr)
  );

  typedef struct {
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] h;
  } res_t;

  typedef struct {
    int               hi;
    int               lo;
    logic [CNT_W-1:0] ep;
    logic [CNT_W-1:0] eh;
  } vec_t;

  res_t exp_q[$];
  vec_t tbl[7];
  int   n_pass = 0;
  int   n_total = 0;
  int   n_xfer = 0;
  int   n_tick = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h);
    res_t r;
    r.p = p;
    r.h = h;
    exp_q.push_back(r);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic seg(input int hi, input int lo);
    clk_in = 1'b1;
    wait_cyc(hi);
    clk_in = 1'b0;
    wait_cyc(lo);
  endtask

  // Scoreboard side: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (edge_tick) n_tick++;
      if (period_valid && period_ready) begin
        res_t e;
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: period %0d high_time %0d with nothing expected",
                   period, high_time);
        end else begin
          e = exp_q.pop_front();
          check("period", period, e.p);
          check("high_time", high_time, e.h);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int k;
    int x0;
    int t0;

    // {high cycles, low cycles, expected period, expected high_time}
    tbl[0] = '{8, 8, 16, 8};
    tbl[1] = '{8, 8, 16, 8};
    tbl[2] = '{8, 8, 16, 8};
    tbl[3] = '{5, 11, 16, 5};
    tbl[4] = '{3, 4, 7, 3};
    tbl[5] = '{20, 10, 30, 20};
    tbl[6] = '{12, 12, 24, 12};

    @(posedge clk);
    #2;
    check("rst_flags", {edge_tick, period_valid, overrun, timeout}, 0);
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    wait_cyc(2);
    rst_n = 1'b1;
    enable = 1'b1;
    period_ready = 1'b1;
    wait_cyc(4);

    // Table-driven periods; each rise closes the previous entry.
    for (int i = 0; i < 7; i++) begin
      if (i > 0) push(tbl[i-1].ep, tbl[i-1].eh);
      seg(tbl[i].hi, tbl[i].lo);
      if (i == 0) check("first_edge_no_result", n_xfer, 0);
    end
    push(tbl[6].ep, tbl[6].eh);
    seg(8, 8);
    check("tbl_drain", exp_q.size(), 0);

    // Overrun with the consumer stalled.
    period_ready = 1'b0;
    seg(8, 8);
    seg(8, 8);
    check("ovr_set", overrun, 1);
    check("ovr_valid_held", period_valid, 1);
    check("ovr_period_kept", period, 16);
    check("ovr_high_kept", high_time, 8);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    check("ovr_clr", overrun, 0);
    // Rise that overwrites while clr is asserted in the same cycle.
    clk_in = 1'b1;
    wait_cyc(2);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    check("ovr_set_wins", overrun, 1);
    check("ovr_tick_align", edge_tick, 1);

    // No further edges: timeout must appear TO cycles after that edge_tick.
    k = 0;
    while (timeout == 1'b0 && k < 300) begin
      wait_cyc(1);
      k++;
      if (k == 5) clk_in = 1'b0;
      if (k == 10) begin
        push(17, 8);
        period_ready = 1'b1;
      end
    end
    check("timeout_latency", k, TO);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    check("timeout_clr", timeout, 0);
    seg(8, 8);
    push(16, 8);
    seg(8, 8);
    push(16, 8);
    seg(8, 8);
    check("rearm_drain", exp_q.size(), 0);

    // Asynchronous reset five cycles into a period.
    clk_in = 1'b1;
    push(16, 8);
    wait_cyc(5);
    rst_n = 1'b0;
    clk_in = 1'b0;
    #1;
    check("async_rst_flags", {edge_tick, period_valid, overrun, timeout}, 0);
    check("async_rst_period", period, 0);
    check("async_rst_high", high_time, 0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);
    x0 = n_xfer;
    seg(8, 8);
    check("post_rst_no_result", n_xfer, x0);
    check("post_rst_valid", period_valid, 0);
    push(16, 8);
    seg(8, 8);
    push(16, 8);
    seg(8, 8);
    check("post_rst_drain", exp_q.size(), 0);

    // Disable mid-period with a pending result.
    period_ready = 1'b0;
    clk_in = 1'b1;
    push(16, 8);
    wait_cyc(5);
    enable = 1'b0;
    wait_cyc(3);
    clk_in = 1'b0;
    wait_cyc(8);
    seg(8, 8);
    seg(8, 8);
    wait_cyc(7);
    check("dis_valid_kept", period_valid, 1);
    check("dis_no_overwrite", overrun, 0);
    check("dis_period_kept", period, 16);
    enable = 1'b1;
    period_ready = 1'b1;
    wait_cyc(2);
    seg(8, 8);
    push(16, 8);
    seg(8, 8);
    push(16, 8);
    seg(8, 8);
    check("reen_drain", exp_q.size(), 0);

    // One-cycle glitch inside a 16-cycle period.
    t0 = n_tick;
    push(16, 8);
    clk_in = 1'b1;
    wait_cyc(8);
    clk_in = 1'b0;
    wait_cyc(3);
    clk_in = 1'b1;
`ifndef CLK_METER_FILTER_EN
    push(11, 8);
`endif
    wait_cyc(1);
    clk_in = 1'b0;
    wait_cyc(4);
`ifdef CLK_METER_FILTER_EN
    push(16, 8);
    seg(8, 8);
    check("glitch_ticks", n_tick - t0, 2);
`else
    push(5, 1);
    seg(8, 8);
    check("glitch_ticks", n_tick - t0, 3);
`endif
    check("glitch_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
